// File: rtl/cp0_status_nest.sv
// CP0 Status register (Reg 12, sel 0) with an exception-nesting context stack
// and a synchronised, masked interrupt-request path.
module cp0_status_nest #(
    parameter int unsigned NIRQ        = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       writeenable,
    input  logic [31:0]                writedata,
    input  logic                       activeexception,
    input  logic                       eret,
    input  logic [NIRQ-1:0]            irq_in,
    output logic [31:0]                statusreg,
    output logic                       iec,
    output logic [NIRQ-1:0]            irq_pending,
    output logic                       int_req,
    output logic [$clog2(DEPTH+1)-1:0] nest_level,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0]   ImMask   = ((32'h1 << NIRQ) - 32'h1) << 8;
    localparam logic [31:0]   WMask    = ImMask | 32'h0000_00FB;
    localparam logic [31:0]   ResetVal = 32'h0000_00E0;
    localparam logic [LW-1:0] LvlFull  = LW'(DEPTH);
    localparam logic [LW-1:0] LvlOne   = LW'(1);

    logic [31:0]     status_q, status_d;
    logic [LW-1:0]   nest_q, nest_d;
    logic [3:0]      stack_q [DEPTH];
    logic [3:0]      stack_d [DEPTH];
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [NIRQ-1:0] sync_q [SYNC_STAGES];
    logic [NIRQ-1:0] sync_d [SYNC_STAGES];
    logic [NIRQ-1:0] pend_q, pend_d;
    logic            ireq_q, ireq_d;

    logic [LW-1:0]   top;
    logic [3:0]      ctx;

    // Next-state: prioritised exception > ERET > MTC0, plus the irq pipeline.
    always_comb begin
        status_d = status_q;
        nest_d   = nest_q;
        stack_d  = stack_q;
        ovf_d    = ovf_q;
        unf_d    = 1'b0;
        top      = nest_q - LvlOne;
        ctx      = stack_q[top[AW-1:0]];

        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pend_d = sync_q[SYNC_STAGES-1] & status_q[8 +: NIRQ];
        // Uses the pre-update Status, hence the extra cycle of latency.
        ireq_d = (|pend_q) & status_q[0] & ~status_q[1];

        if (activeexception) begin
            if (nest_q != LvlFull) begin
                stack_d[nest_q[AW-1:0]] = {status_q[4:3], status_q[1], status_q[0]};
                nest_d = nest_q + LvlOne;
            end else begin
                ovf_d = 1'b1;
            end
            status_d[4:3] = 2'b00;
            status_d[1]   = 1'b1;
            status_d[0]   = 1'b0;
        end else if (eret) begin
            if (nest_q != '0) begin
                status_d[4:3] = ctx[3:2];
                status_d[1]   = ctx[1];
                status_d[0]   = ctx[0];
                nest_d        = top;
            end else begin
                // Empty stack: fall back to single-level ERET semantics.
                status_d[1] = 1'b0;
                status_d[0] = 1'b1;
                unf_d       = 1'b1;
            end
        end else if (writeenable) begin
            status_d = writedata & WMask;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= ResetVal;
            nest_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            pend_q   <= '0;
            ireq_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            status_q <= status_d;
            nest_q   <= nest_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            pend_q   <= pend_d;
            ireq_q   <= ireq_d;
            stack_q  <= stack_d;
            sync_q   <= sync_d;
        end
    end

    // Output mapping.
    always_comb begin
        statusreg       = status_q;
        iec             = status_q[0];
        irq_pending     = pend_q;
        int_req         = ireq_q;
        nest_level      = nest_q;
        stack_overflow  = ovf_q;
        stack_underflow = unf_q;
    end

endmodule

// File: tb/tb_cp0_status_nest.sv
// Scoreboard bench for cp0_status_nest: directed scenarios then random traffic,
// checked against a field-level model of Status, a queue-based stack and an
// irq delay line.
module tb_cp0_status_nest;

    localparam int NIRQ  = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            writeenable = 1'b0;
    logic [31:0]     writedata = '0;
    logic            activeexception = 1'b0;
    logic            eret = 1'b0;
    logic [NIRQ-1:0] irq_in = '0;
    logic [31:0]     statusreg;
    logic            iec;
    logic [NIRQ-1:0] irq_pending;
    logic            int_req;
    logic [LW-1:0]   nest_level;
    logic            stack_overflow;
    logic            stack_underflow;

    cp0_status_nest #(.NIRQ(NIRQ), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk             (clk),
        .reset           (reset),
        .writeenable     (writeenable),
        .writedata       (writedata),
        .activeexception (activeexception),
        .eret            (eret),
        .irq_in          (irq_in),
        .statusreg       (statusreg),
        .iec             (iec),
        .irq_pending     (irq_pending),
        .int_req         (int_req),
        .nest_level      (nest_level),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     st;
        int              nest;
        logic            ovf;
        logic            unf;
        logic [NIRQ-1:0] pend;
        logic            ireq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit            m_ie, m_exl, m_ux, m_sx, m_kx;
    bit [1:0]      m_ksu;
    bit [NIRQ-1:0] m_im, m_pend;
    bit            m_ireq, m_ovf, m_unf;
    bit [3:0]      m_stack[$];
    bit [NIRQ-1:0] m_hist[$];
    logic [NIRQ-1:0] irq_cur = '0;

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]   = m_ie;
        s[1]   = m_exl;
        s[4:3] = m_ksu;
        s[5]   = m_ux;
        s[6]   = m_sx;
        s[7]   = m_kx;
        for (int i = 0; i < NIRQ; i++) s[8+i] = m_im[i];
        return s;
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_ksu = 0; m_ux = 1; m_sx = 1; m_kx = 1; m_im = 0;
        m_pend = 0; m_ireq = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
    endtask

    // One clock: drive inputs, advance the model, queue the expected outputs.
    task automatic step(input bit r, input bit ex, input bit er, input bit we,
                        input logic [31:0] wd, input logic [NIRQ-1:0] irq);
        bit [NIRQ-1:0] delayed;
        bit            new_ireq;
        bit [3:0]      c;
        exp_t          e;
        @(negedge clk);
        reset = r; activeexception = ex; eret = er; writeenable = we;
        writedata = wd; irq_in = irq;
        if (r) begin
            model_reset();
        end else begin
            delayed  = m_hist.pop_front();
            m_hist.push_back(irq);
            new_ireq = (m_pend != 0) && m_ie && !m_exl;
            m_pend   = delayed & m_im;
            m_ireq   = new_ireq;
            m_unf    = 0;
            if (ex) begin
                if (m_stack.size() < DEPTH) m_stack.push_back({m_ksu, m_exl, m_ie});
                else m_ovf = 1;
                m_exl = 1; m_ie = 0; m_ksu = 0;
            end else if (er) begin
                if (m_stack.size() > 0) begin
                    c = m_stack.pop_back();
                    m_ksu = c[3:2]; m_exl = c[1]; m_ie = c[0];
                end else begin
                    m_exl = 0; m_ie = 1; m_unf = 1;
                end
            end else if (we) begin
                m_ie = wd[0]; m_exl = wd[1]; m_ksu = wd[4:3];
                m_ux = wd[5]; m_sx = wd[6]; m_kx = wd[7];
                m_im = wd[8 +: NIRQ];
            end
        end
        e.st = m_status(); e.nest = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf;
        e.pend = m_pend; e.ireq = m_ireq;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, irq_cur);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a new state, compare against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("statusreg", statusreg, e.st);
            chk("iec", 32'(iec), 32'(e.st[0]));
            chk("nest_level", 32'(nest_level), e.nest);
            chk("stack_overflow", 32'(stack_overflow), 32'(e.ovf));
            chk("stack_underflow", 32'(stack_underflow), 32'(e.unf));
            chk("irq_pending", 32'(irq_pending), 32'(e.pend));
            chk("int_req", 32'(int_req), 32'(e.ireq));
        end
    end

    initial begin
        model_reset();
        step(1, 0, 0, 0, 32'h0, '0);
        step(1, 0, 0, 0, 32'h0, '0);
        idle(3);

        // MTC0 all ones, then an interrupt with EXL cleared so int_req can rise
        step(0, 0, 0, 1, 32'hFFFF_FFFF, irq_cur);
        irq_cur = 8'h08;
        idle(5);
        step(0, 0, 0, 1, 32'hFFFF_FFF9, irq_cur);
        idle(4);
        irq_cur = '0;
        idle(4);

        // Two-level nesting with restore
        step(0, 0, 0, 1, 32'h0000_FF01, irq_cur);
        step(0, 1, 0, 0, 32'h0, irq_cur);
        step(0, 0, 0, 1, 32'h0000_FF03, irq_cur);
        step(0, 1, 0, 0, 32'h0, irq_cur);
        step(0, 0, 1, 0, 32'h0, irq_cur);
        step(0, 0, 1, 0, 32'h0, irq_cur);
        idle(1);

        // Overflow then underflow
        step(0, 0, 0, 1, 32'h0000_A519, irq_cur);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'h0, irq_cur);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'h0, irq_cur);
        idle(2);

        // Simultaneous events
        step(0, 1, 1, 1, 32'h0000_0000, irq_cur);
        step(0, 0, 1, 1, 32'hFFFF_FFFF, irq_cur);
        idle(1);

        // Reset mid-nesting with all irq lines high
        step(0, 0, 0, 1, 32'h0000_FF01, irq_cur);
        irq_cur = '1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, irq_cur);
        step(0, 0, 1, 1, 32'h0000_FF01, irq_cur);
        step(0, 1, 0, 0, 32'h0, irq_cur);
        step(1, 0, 0, 0, 32'h0, irq_cur);
        idle(4);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, ex, er, we;
            r  = ($urandom_range(0, 199) == 0);
            ex = ($urandom_range(0, 99) < 15);
            er = ($urandom_range(0, 99) < 15);
            we = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 7) == 0) irq_cur = NIRQ'($urandom);
            step(r, ex, er, we, $urandom, irq_cur);
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
